// File: rtl/fft_r2sdf_bfly.sv
// Radix-2 single-path delay-feedback butterfly stage.
// One complex sample in per accepted cycle; one DW+1-bit butterfly result out, registered.
module fft_r2sdf_bfly #(
  parameter int unsigned DW    = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 din_valid,
  input  logic signed [DW-1:0] din_re,
  input  logic signed [DW-1:0] din_im,
  output logic                 dout_valid,
  output logic signed [DW:0]   dout_re,
  output logic signed [DW:0]   dout_im
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]      r_cnt;
  logic               r_primed;
  logic signed [DW:0] r_dl_re [DEPTH];
  logic signed [DW:0] r_dl_im [DEPTH];
  logic signed [DW:0] r_dout_re;
  logic signed [DW:0] r_dout_im;
  logic               r_dout_valid;

  logic               w_accept;
  logic               w_phase;
  logic               w_wrap;
  logic signed [DW:0] w_in_re;
  logic signed [DW:0] w_in_im;
  logic signed [DW:0] w_head_re;
  logic signed [DW:0] w_head_im;
  logic signed [DW:0] w_push_re;
  logic signed [DW:0] w_push_im;
  logic signed [DW:0] w_out_re;
  logic signed [DW:0] w_out_im;

  assign w_accept  = din_valid & ~clr;
  assign w_phase   = r_cnt[CW-1];
  assign w_wrap    = (r_cnt == CW'(2 * DEPTH - 1));
  assign w_in_re   = {din_re[DW-1], din_re};
  assign w_in_im   = {din_im[DW-1], din_im};
  assign w_head_re = r_dl_re[DEPTH-1];
  assign w_head_im = r_dl_im[DEPTH-1];

  // Phase 0 forwards the previous frame's difference and stores the input;
  // phase 1 emits the sum and stores the difference.
  always_comb begin
    w_push_re = w_in_re;
    w_push_im = w_in_im;
    w_out_re  = w_head_re;
    w_out_im  = w_head_im;
    if (w_phase) begin
      w_push_re = w_head_re - w_in_re;
      w_push_im = w_head_im - w_in_im;
      w_out_re  = w_head_re + w_in_re;
      w_out_im  = w_head_im + w_in_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_primed     <= 1'b0;
      r_dout_re    <= '0;
      r_dout_im    <= '0;
      r_dout_valid <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_dl_re[i] <= '0;
        r_dl_im[i] <= '0;
      end
    end else if (clr) begin
      r_cnt        <= '0;
      r_primed     <= 1'b0;
      r_dout_valid <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_dl_re[i] <= '0;
        r_dl_im[i] <= '0;
      end
    end else if (w_accept) begin
      // 2*DEPTH is a power of two, so the counter wraps on its own.
      r_cnt        <= r_cnt + 1'b1;
      r_primed     <= r_primed | w_wrap;
      r_dout_re    <= w_out_re;
      r_dout_im    <= w_out_im;
      r_dout_valid <= w_phase | r_primed;
      r_dl_re[0]   <= w_push_re;
      r_dl_im[0]   <= w_push_im;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_dl_re[i] <= r_dl_re[i-1];
        r_dl_im[i] <= r_dl_im[i-1];
      end
    end else begin
      r_dout_valid <= 1'b0;
    end
  end

  assign dout_valid = r_dout_valid;
  assign dout_re    = r_dout_re;
  assign dout_im    = r_dout_im;

endmodule

// File: tb/tb_fft_r2sdf_bfly.sv
// Bench for fft_r2sdf_bfly: directed scenarios plus random traffic against a frame-level model.
module tb_fft_r2sdf_bfly;

  localparam int DW = 10;
  localparam int D  = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clr = 1'b0;
  logic                 din_valid = 1'b0;
  logic signed [DW-1:0] din_re = '0;
  logic signed [DW-1:0] din_im = '0;
  logic                 dout_valid;
  logic signed [DW:0]   dout_re;
  logic signed [DW:0]   dout_im;

  int n_vec = 0;
  int n_err = 0;

  fft_r2sdf_bfly #(.DW(DW), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .din_valid (din_valid),
    .din_re    (din_re),
    .din_im    (din_im),
    .dout_valid(dout_valid),
    .dout_re   (dout_re),
    .dout_im   (dout_im)
  );

  always #5 clk = ~clk;

  // Frame model: first half stored, second half forms sum/diff, diffs replayed next frame.
  int m_first_re[D], m_first_im[D];
  int m_cur_re[D],   m_cur_im[D];
  int m_prev_re[D],  m_prev_im[D];
  int m_idx;
  bit m_primed;
  bit e_valid;
  int e_re, e_im;

  function automatic void model_clear();
    m_idx = 0;
    m_primed = 1'b0;
    for (int i = 0; i < D; i++) begin
      m_first_re[i] = 0; m_first_im[i] = 0;
      m_cur_re[i] = 0;   m_cur_im[i] = 0;
      m_prev_re[i] = 0;  m_prev_im[i] = 0;
    end
  endfunction

  function automatic void model_step(input bit v, input bit c, input int re, input int im);
    int k;
    if (c) begin
      model_clear();
      e_valid = 1'b0;
    end else if (v) begin
      if (m_idx < D) begin
        e_re = m_prev_re[m_idx];
        e_im = m_prev_im[m_idx];
        m_first_re[m_idx] = re;
        m_first_im[m_idx] = im;
        e_valid = m_primed;
      end else begin
        k = m_idx - D;
        e_re = m_first_re[k] + re;
        e_im = m_first_im[k] + im;
        m_cur_re[k] = m_first_re[k] - re;
        m_cur_im[k] = m_first_im[k] - im;
        e_valid = 1'b1;
      end
      if (m_idx == 2 * D - 1) begin
        m_prev_re = m_cur_re;
        m_prev_im = m_cur_im;
        m_primed = 1'b1;
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end else begin
      e_valid = 1'b0;
    end
  endfunction

  function automatic int sat10(input int x);
    if (x > 511) return 511;
    if (x < -512) return -512;
    return x;
  endfunction

  function automatic int rnd10();
    int r;
    r = int'($urandom_range(1023)) - 512;
    return r;
  endfunction

  task automatic step(input bit v, input bit c, input int re, input int im);
    din_valid = v;
    clr = c;
    din_re = DW'(re);
    din_im = DW'(im);
    @(posedge clk);
    model_step(v, c, re, im);
    #1;
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    clr = 1'b0;
    rst_n = 1'b0;
    #3;
    model_clear();
    e_valid = 1'b0;
    e_re = 0;
    e_im = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Basic frame with optional idle cycles after every sample.
  task automatic frame_checked(input string tag, input int gaps);
    int seq[12]   = '{1, 2, 3, 4, 10, 20, 30, 40, 0, 0, 0, 0};
    bit exp_v[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    int exp_o[12] = '{0, 0, 0, 0, 11, 22, 33, 44, -9, -18, -27, -36};
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, seq[i], 0);
      n_vec++;
      if (dout_valid !== exp_v[i]) begin
        n_err++;
        $display("FAIL %s valid[%0d]: got %b want %b", tag, i, dout_valid, exp_v[i]);
      end
      if (exp_v[i]) begin
        n_vec++;
        if (dout_re !== 11'(exp_o[i]) || dout_im !== 11'(0)) begin
          n_err++;
          $display("FAIL %s data[%0d]: got %0d/%0d want %0d/0", tag, i, dout_re, dout_im,
                   exp_o[i]);
        end
      end
      for (int g = 0; g < gaps; g++) begin
        step(1'b0, 1'b0, rnd10(), rnd10());
        n_vec++;
        if (dout_valid !== 1'b0) begin
          n_err++;
          $display("FAIL %s gap_valid[%0d]: got %b want 0", tag, i, dout_valid);
        end
        if (exp_v[i]) begin
          n_vec++;
          if (dout_re !== 11'(exp_o[i]) || dout_im !== 11'(0)) begin
            n_err++;
            $display("FAIL %s gap_hold[%0d]: got %0d/%0d want %0d/0", tag, i, dout_re, dout_im,
                     exp_o[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, i + 1, i + 2);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (dout_valid !== 1'b0 || dout_re !== 11'(0) || dout_im !== 11'(0)) begin
      n_err++;
      $display("FAIL reset_async: got %b %0d %0d want 0 0 0", dout_valid, dout_re, dout_im);
    end
    model_clear();
    e_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 0, 0);
      n_vec++;
      if (dout_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: got %b want 0", i, dout_valid);
      end
    end
    // Mid-frame reset leaves a fresh frame alignment behind.
    frame_checked("reset_then_basic", 0);
  endtask

  task automatic test_basic();
    do_reset();
    frame_checked("basic", 0);
  endtask

  task automatic test_extremes();
    int seq[12]   = '{511, -512, 511, -512, 511, -512, -512, 511, 0, 0, 0, 0};
    int exp_o[12] = '{0, 0, 0, 0, 1022, -1024, -1, -1, 0, 0, 1023, -1023};
    int exp_s[12] = '{0, 0, 0, 0, 511, -512, -1, -1, 0, 0, 511, -512};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, seq[i], seq[i]);
      n_vec++;
      if (dout_valid !== (i >= D)) begin
        n_err++;
        $display("FAIL extremes valid[%0d]: got %b want %b", i, dout_valid, i >= D);
      end
      if (i >= D) begin
        n_vec++;
        if (dout_re !== 11'(exp_o[i]) || dout_im !== 11'(exp_o[i])) begin
          n_err++;
          $display("FAIL extremes data[%0d]: got %0d/%0d want %0d", i, dout_re, dout_im,
                   exp_o[i]);
        end
        n_vec++;
        if (sat10(int'(dout_re)) !== exp_s[i]) begin
          n_err++;
          $display("FAIL extremes sat[%0d]: got %0d want %0d", i, sat10(int'(dout_re)),
                   exp_s[i]);
        end
      end
    end
  endtask

  task automatic test_stalls();
    do_reset();
    frame_checked("stall", 2);
  endtask

  task automatic test_clr_midframe();
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, rnd10(), rnd10());
    step(1'b1, 1'b1, 99, 99);
    n_vec++;
    if (dout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL clr_valid: got %b want 0", dout_valid);
    end
    frame_checked("clr", 0);
  endtask

  task automatic test_complex_continuous();
    int a[2*D], b[2*D], d;
    do_reset();
    for (int i = 0; i < 2 * D; i++) begin
      a[i] = int'($urandom_range(1022)) - 511;
      b[i] = int'($urandom_range(1022)) - 511;
    end
    for (int i = 0; i < 2 * D; i++) step(1'b1, 1'b0, a[i], -a[i]);
    for (int i = 0; i < 2 * D; i++) begin
      step(1'b1, 1'b0, b[i], -b[i]);
      n_vec++;
      if (dout_valid !== 1'b1) begin
        n_err++;
        $display("FAIL complex valid[%0d]: got %b want 1", i, dout_valid);
      end
      if (i < D) begin
        d = a[i] - a[i+D];
        n_vec++;
        if (dout_re !== 11'(d) || dout_im !== 11'(-d)) begin
          n_err++;
          $display("FAIL complex diff[%0d]: got %0d/%0d want %0d/%0d", i, dout_re, dout_im, d,
                   -d);
        end
      end else begin
        n_vec++;
        if (dout_re !== 11'(e_re) || dout_im !== 11'(e_im)) begin
          n_err++;
          $display("FAIL complex sum[%0d]: got %0d/%0d want %0d/%0d", i, dout_re, dout_im,
                   e_re, e_im);
        end
      end
    end
  endtask

  task automatic test_random();
    bit v, c;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(99) < 70);
      c = ($urandom_range(99) < 3);
      step(v, c, rnd10(), rnd10());
      n_vec++;
      if (dout_valid !== e_valid) begin
        n_err++;
        $display("FAIL random valid[%0d]: got %b want %b", i, dout_valid, e_valid);
      end
      if (e_valid) begin
        n_vec++;
        if (dout_re !== 11'(e_re) || dout_im !== 11'(e_im)) begin
          n_err++;
          $display("FAIL random data[%0d]: got %0d/%0d want %0d/%0d", i, dout_re, dout_im,
                   e_re, e_im);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_stalls();
    test_clr_midframe();
    test_complex_continuous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
